// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the FIFO-draining UART transmitter.
package uart_tx_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity for one data word: even = XOR of bits, odd = its inverse.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_par
);

  logic w_even;

  assign w_even = ^i_data;
  assign o_par  = (i_par_typ == PAR_ODD) ? ~w_even : w_even;

endmodule

// File: rtl/fifo_rd_uart_tx.sv
// FIFO read-side consumer: pops one word per UART frame and serialises it on TX_OUT.
module fifo_rd_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic                  R_EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  R_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int unsigned       CntW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0]   CntLast = CntW'(DATA_WIDTH - 1);

  tx_state_e             r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic                  r_par_en, r_par_bit, w_par_bit;
  logic                  r_tx, w_tx_d, r_busy;
  logic                  w_pop;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (RD_DATA),
    .i_par_typ(PAR_TYP),
    .o_par    (w_par_bit)
  );

  // Pop only from a frame boundary so consecutive frames stay gap-free.
  assign w_pop  = ((r_state == StIdle) || (r_state == StStop)) && !R_EMPTY && !R_RST;
  assign R_INC  = w_pop;
  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;

  always_comb begin
    w_state_d = r_state;
    w_shift_d = r_shift;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle:   if (w_pop) w_state_d = StStart;
      StStart:  w_state_d = StData;
      StData: begin
        if (r_cnt == CntLast) begin
          w_cnt_d   = '0;
          w_state_d = r_par_en ? StParity : StStop;
        end else begin
          w_cnt_d   = r_cnt + 1'b1;
          w_shift_d = r_shift >> 1;
        end
      end
      StParity: w_state_d = StStop;
      StStop:   w_state_d = w_pop ? StStart : StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (w_pop) w_shift_d = RD_DATA;
  end

  // Line level is registered from the upcoming state so it lines up with the state.
  always_comb begin
    w_tx_d = 1'b1;
    unique case (w_state_d)
      StStart:  w_tx_d = 1'b0;
      StData:   w_tx_d = w_shift_d[0];
      StParity: w_tx_d = r_par_bit;
      default:  w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge R_CLK or posedge R_RST) begin
    if (R_RST) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_shift <= w_shift_d;
      r_cnt   <= w_cnt_d;
      r_tx    <= w_tx_d;
      r_busy  <= (w_state_d != StIdle);
      if (w_pop) begin
        r_par_en  <= PAR_EN;
        r_par_bit <= w_par_bit;
      end
    end
  end

endmodule
